// File: rtl/circuit2_pkg.sv
// Shared defaults, widths and the result-pair type for the circuit2 result FIFO.
package circuit2_pkg;

    localparam int unsigned DATAWIDTH_DEFAULT = 32;
    localparam int unsigned DEPTH_DEFAULT     = 4;
    localparam int unsigned STATS_W           = 16;

    typedef struct packed {
        logic [DATAWIDTH_DEFAULT-1:0] x;
        logic [DATAWIDTH_DEFAULT-1:0] z;
    } result_pair_t;

    // Occupancy needs one more bit than the pointers to represent DEPTH itself.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/circuit2_fifo_ctrl.sv
// Pointer, occupancy and full tracking for the circuit2 result FIFO.
module circuit2_fifo_ctrl
    import circuit2_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_req_i,
    input  logic             pop_ready_i,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             push_c_o,
    output logic             pop_c_o,
    output logic             drop_c_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign pop_c_o  = (count_q != '0) & pop_ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push_c_o = push_req_i & (~full_o | pop_c_o);
    assign drop_c_o = push_req_i & ~push_c_o;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c_o) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c_o)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_c_o, pop_c_o})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/circuit2_result_fifo.sv
// Result-pair FIFO: buffers {x, z} results, sticky overflow on drops.
// Define CIRCUIT2_RESULT_STATS_EN to add saturating accept/drop counters.
module circuit2_result_fifo
    import circuit2_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEFAULT,
    parameter int unsigned DEPTH     = DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATAWIDTH-1:0]          x_in,
    input  logic [DATAWIDTH-1:0]          z_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATAWIDTH-1:0]          out_x,
    output logic [DATAWIDTH-1:0]          out_z,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          overflow
`ifdef CIRCUIT2_RESULT_STATS_EN
    ,
    output logic [STATS_W-1:0]            accept_cnt,
    output logic [STATS_W-1:0]            drop_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_width(DEPTH);

    typedef struct packed {
        logic [DATAWIDTH-1:0] x;
        logic [DATAWIDTH-1:0] z;
    } pair_t;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push_c, pop_c, drop_c;
    logic             overflow_q;
    pair_t            mem_q [DEPTH];
    pair_t            head;

    circuit2_fifo_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .push_req_i  (in_valid),
        .pop_ready_i (out_ready),
        .wr_ptr_o    (wr_ptr),
        .rd_ptr_o    (rd_ptr),
        .count_o     (count),
        .full_o      (full),
        .push_c_o    (push_c),
        .pop_c_o     (pop_c),
        .drop_c_o    (drop_c)
    );

    // Storage holds no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr] <= {x_in, z_in};
    end

    always_ff @(posedge clk) begin
        if (rst)         overflow_q <= 1'b0;
        else if (drop_c) overflow_q <= 1'b1;
    end

    assign head      = mem_q[rd_ptr];
    assign out_valid = (count != '0);
    assign out_x     = out_valid ? head.x : '0;
    assign out_z     = out_valid ? head.z : '0;
    assign overflow  = overflow_q;

`ifdef CIRCUIT2_RESULT_STATS_EN
    logic [STATS_W-1:0] accept_cnt_q, drop_cnt_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            accept_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            if (push_c && accept_cnt_q != '1) accept_cnt_q <= accept_cnt_q + STATS_W'(1);
            if (drop_c && drop_cnt_q != '1)   drop_cnt_q   <= drop_cnt_q + STATS_W'(1);
        end
    end

    assign accept_cnt = accept_cnt_q;
    assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: doc/circuit2_result_fifo.md
CIRCUIT2_RESULT_FIFO -- requirements
Module: circuit2_result_fifo

Interface
REQ-001 Parameter DATAWIDTH, default 32, width of each result word (x and z).
REQ-002 Parameter DEPTH, default 4, number of result-pair entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  x_in/z_in carry a new result pair this cycle.
REQ-006 x_in  input  DATAWIDTH  registered x result from the upstream datapath stage.
REQ-007 z_in  input  DATAWIDTH  registered z result from the upstream datapath stage.
REQ-008 out_valid  output  1  head entry present on out_x/out_z.
REQ-009 out_ready  input  1  consumer accepts head entry this cycle.
REQ-010 out_x  output  DATAWIDTH  x of head entry.
REQ-011 out_z  output  DATAWIDTH  z of head entry.
REQ-012 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 full  output  1  count == DEPTH.
REQ-014 overflow  output  1  sticky flag: a result was dropped.

Function
REQ-015 Push SHALL occur when in_valid=1 and (full=0 or a pop occurs in the same cycle).
REQ-016 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-017 out_valid SHALL equal (count != 0).
REQ-018 out_x/out_z SHALL show the head entry whenever out_valid=1, and SHALL be 0 whenever out_valid=0.
REQ-019 A pair pushed at edge N SHALL be visible on out_x/out_z after edge N, if the FIFO was empty; latency is one cycle.
REQ-020 Entries SHALL leave in push order; x and z of one push SHALL always leave together.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including when full (push accepted) and when count=1 (new entry becomes head).
REQ-022 in_valid=1 while full=1 with no pop SHALL drop the pair, leave contents unchanged, and set overflow=1.
REQ-023 overflow SHALL remain 1 until reset.
REQ-024 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 out_ready while empty SHALL have no effect; count never underflows.

Reset
REQ-026 rst=1 at an edge SHALL clear pointers, count, overflow, and statistics counters; out_valid=0, out_x=0, out_z=0, full=0 after that edge.
REQ-027 rst SHALL take priority over a simultaneous push or pop; in-flight entries are discarded.

Configuration
REQ-028 Macro CIRCUIT2_RESULT_STATS_EN defined: add outputs accept_cnt and drop_cnt, each 16 bits, counting pushes and drops, both saturating at 0xFFFF.
REQ-029 Macro undefined: accept_cnt and drop_cnt ports and logic are absent; all other behaviour is identical.

Structure
REQ-030 Shared package circuit2_pkg SHALL hold the DATAWIDTH default, the DEPTH default, the count-width function, the stats counter width, and a result-pair typedef {x, z}.
REQ-031 Pointer, count, and full logic SHALL sit in one sub-module circuit2_fifo_ctrl; storage and output muxing SHALL stay in the top module.

Verification
REQ-032 Reset, then push x=0x00000005, z=0x00000002 -> next cycle out_valid=1, out_x=5, out_z=2, count=1.
REQ-033 Push 4 pairs (x=1..4) with out_ready=0 -> full=1, count=4; push x=9 -> overflow=1, 9 never appears; drain yields 1,2,3,4.
REQ-034 Full FIFO, in_valid and out_ready both 1 with x=0xAA -> count stays 4; 0xAA emerges after the three older entries.
REQ-035 Continuous push and pop for 10 cycles -> pointer wrap verified; order preserved; count stays 1.
REQ-036 Assert rst with count=3 -> next cycle count=0, out_valid=0, out_x=0, overflow=0.
REQ-037 With CIRCUIT2_RESULT_STATS_EN, 6 pushes into DEPTH=4 with no pops -> accept_cnt=4, drop_cnt=2.
